imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Instruction-memory responder at the far end of the fetch interface. The fetch stage issues a word fetch; this block serves it from a loadable instruction store after a programmable number of wait states.
- Exposes a ready/valid handshake and a busy flag that feeds the pipeline freeze logic.
- Supports cancellation of an outstanding fetch on a taken branch (flush).

Parameters:
- WORD_LEN, 32, instruction/data/address width in bits.
- DEPTH, 1024, number of instruction words in the store.
- WAIT_CYCLES, 2, wait states per fetch; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request from the fetch stage.
- req_addr  in  WORD_LEN  byte address (PC).
- req_ready  out  1  responder can accept a request this cycle.
- flush  in  1  cancel any outstanding fetch (branch taken).
- resp_valid  out  1  resp_instr/resp_addr/resp_err are valid.
- resp_ready  in  1  consumer accepts the response; low means frozen.
- resp_instr  out  WORD_LEN  fetched instruction word.
- resp_addr  out  WORD_LEN  byte address of the returned word.
- resp_err  out  1  address was misaligned or out of range.
- busy  out  1  a fetch is in progress (state WAIT); drives freeze.
- load_en  in  1  write one word into the store.
- load_addr  in  clog2(DEPTH)  word index for the load.
- load_data  in  WORD_LEN  word to store.

Behaviour:
- Reset:
  - State goes to IDLE and the wait counter goes to 0.
  - resp_valid, resp_instr, resp_addr and resp_err all go to 0.
  - Store contents are not cleared by reset.
- States:
  - IDLE -> WAIT on handshake (req_valid & req_ready) when WAIT_CYCLES > 0.
  - IDLE -> RESP on handshake when WAIT_CYCLES = 0.
  - WAIT -> RESP when the counter reaches WAIT_CYCLES-1.
  - RESP -> IDLE when resp_ready = 1.
- Outputs by state:
  - req_ready = (state == IDLE) & ~rst.
  - busy = (state == WAIT).
- Request capture: the handshake edge registers req_addr and clears the counter. The counter increments once per WAIT cycle.
- Latency: a handshake on edge T gives resp_valid = 1 on edge T+1+WAIT_CYCLES.
- Read: resp_instr is loaded on the edge that enters RESP, from store contents before that edge. A load on that same edge is not visible to that response; earlier loads are visible.
- Hold: in RESP, resp_valid, resp_instr, resp_addr and resp_err stay stable until resp_ready = 1. resp_valid falls on the edge after acceptance. No new request is accepted while in RESP.
- Error handling: resp_err = 1 and resp_instr = 0 (NOP) when either condition holds:
  - req_addr[1:0] != 0 (misaligned);
  - req_addr[WORD_LEN-1:2] >= DEPTH (out of range).
- Valid addresses: word index is req_addr >> 2; resp_err = 0.
- resp_addr always echoes the captured request address.
- Flush:
  - In WAIT: return to IDLE on the next edge; no response is ever produced.
  - In RESP: resp_valid falls on the next edge, regardless of resp_ready.
  - In IDLE: no effect. A req_valid in the same cycle is still accepted (the redirected PC is the new request).
- Simultaneous handshake and load to the same address: the response returns the word as of the read edge, per the rule above.
- Reset mid-operation: an outstanding fetch is dropped and all outputs return to reset values on the same edge.
- Loads:
  - Accepted in any state, including during reset.
  - A load to load_addr >= DEPTH is ignored.

Test Plan:
- Basic fetch:
  - Stimulus: WAIT_CYCLES=2; load word 3 = 0x20080005; req_addr = 0x0000000C accepted at edge T.
  - Expected: busy is high for 2 cycles; resp_valid = 1 at T+3 with resp_instr = 0x20080005, resp_addr = 0x0C, resp_err = 0.
- Zero wait / back-to-back:
  - Stimulus: WAIT_CYCLES=0; requests to 0x0, 0x4, 0x8, 0xC with resp_ready held at 1.
  - Expected: responses appear in order, each 1 cycle after acceptance; req_ready alternates 1/0.
- Backpressure:
  - Stimulus: resp_ready = 0 for 4 cycles while in RESP.
  - Expected: outputs held stable and req_ready = 0 throughout; a single transfer completes when resp_ready rises.
- Flush:
  - Stimulus: flush asserted during the second WAIT cycle of a fetch to 0x10.
  - Expected: no resp_valid; IDLE next cycle.
  - Follow-up: a request to 0x40 accepted in that IDLE cycle returns word 16 after the normal latency.
- Errors:
  - Stimulus: req_addr = 0x6 (misaligned).
  - Expected: resp_err = 1, resp_instr = 0.
  - Stimulus: with DEPTH=1024, req_addr = 0x1000 (out of range).
  - Expected: resp_err = 1, resp_instr = 0.
- Reset mid-fetch:
  - Stimulus: rst pulsed for 1 cycle while in WAIT.
  - Expected: resp_valid = 0, busy = 0, req_ready = 1 after reset.
  - Follow-up: previously loaded words are still readable.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one word fetch at a time, serves it from a
// loadable store after WAIT_CYCLES wait states, and can cancel it on a flush.
module imem_responder #(
  parameter int WORD_LEN    = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [WORD_LEN-1:0]      req_addr,
  output logic                     req_ready,
  input  logic                     flush,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WORD_LEN-1:0]      resp_instr,
  output logic [WORD_LEN-1:0]      resp_addr,
  output logic                     resp_err,
  output logic                     busy,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [WORD_LEN-1:0]      load_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0]          CNT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [WORD_LEN-1:0] DEPTH_W  = WORD_LEN'(DEPTH);
  localparam logic [AW:0]         DEPTH_L  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic [WORD_LEN-1:0] addr_p0;
  logic [WORD_LEN-1:0] mem [DEPTH];

  logic                hs;
  logic                enter_resp;
  logic [WORD_LEN-1:0] rd_addr;
  logic                rd_err;
  logic [AW-1:0]       rd_idx;

  function automatic logic addr_err(input logic [WORD_LEN-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH_W);
  endfunction

  assign hs         = req_valid & req_ready;
  assign enter_resp = (state_nxt == S_RESP) && (state != S_RESP);

  // With zero wait states the read happens on the handshake edge itself,
  // before the request address has been captured.
  assign rd_addr = (state == S_IDLE) ? req_addr : addr_p0;
  assign rd_err  = addr_err(rd_addr);
  assign rd_idx  = rd_addr[AW+1:2];

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (hs) state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: begin
        if (flush)                 state_nxt = S_IDLE;
        else if (cnt == CNT_LAST)  state_nxt = S_RESP;
      end
      S_RESP: if (flush || resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    req_ready  = (state == S_IDLE) & ~rst;
    busy       = (state == S_WAIT);
    resp_valid = (state == S_RESP);
  end

  // capture stage: request address and wait-state counter
  always_ff @(posedge clk) begin
    if (rst)                  cnt <= 4'd0;
    else if (hs)              cnt <= 4'd0;
    else if (state == S_WAIT) cnt <= cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (hs) addr_p0 <= req_addr;
  end

  // response stage: registered on the edge that enters RESP, held until it leaves
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_instr <= '0;
      resp_addr  <= '0;
      resp_err   <= 1'b0;
    end else if (enter_resp) begin
      resp_addr  <= rd_addr;
      resp_err   <= rd_err;
      resp_instr <= rd_err ? '0 : mem[rd_idx];
    end
  end

  // Store writes are independent of reset and of the fetch state.
  always_ff @(posedge clk) begin
    if (load_en && ({1'b0, load_addr} < DEPTH_L)) mem[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_imem_responder.sv
// Randomised scoreboard bench for imem_responder: one instance with two wait
// states and one with zero wait states, sharing clock, reset, flush and load bus.
module tb_imem_responder;

  localparam int W2    = 2;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, load_en;
  logic [9:0]  load_addr;
  logic [31:0] load_data;

  logic        rv2, rr2, rdy2, v2, err2, busy2;
  logic [31:0] ra2, instr2, raddr2;
  logic        rv0, rr0, rdy0, v0, err0, busy0;
  logic [31:0] ra0, instr0, raddr0;

  imem_responder #(.WORD_LEN(32), .DEPTH(DEPTH), .WAIT_CYCLES(W2)) dut (
    .clk(clk), .rst(rst), .req_valid(rv2), .req_addr(ra2), .req_ready(rdy2),
    .flush(flush), .resp_valid(v2), .resp_ready(rr2), .resp_instr(instr2),
    .resp_addr(raddr2), .resp_err(err2), .busy(busy2),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  imem_responder #(.WORD_LEN(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_addr(ra0), .req_ready(rdy0),
    .flush(flush), .resp_valid(v0), .resp_ready(rr0), .resp_instr(instr0),
    .resp_addr(raddr0), .resp_err(err0), .busy(busy0),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
    int          t;
  } exp_t;

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          acc2 = 0;
  exp_t        q2[$];
  exp_t        q0[$];
  exp_t        cur2, cur0;
  bit          hold2 = 0, hold0 = 0, rnd_bp = 0;
  logic [31:0] mem_m [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: word-addressed store, error on misalignment or index past DEPTH.
  function automatic exp_t mk(input logic [31:0] a, input int t);
    exp_t e;
    e.addr  = a;
    e.t     = t;
    e.err   = (a % 4 != 0) || (a / 4 >= DEPTH);
    e.instr = e.err ? 32'h0 : mem_m[a / 4];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_bp) rr2 = ($urandom_range(0, 3) != 0);
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = idx[9:0];
    load_data = d;
    tick();
    mem_m[idx] = d;
    load_en    = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input bit push);
    rv2 = 1'b1;
    ra2 = a;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rdy2) begin
        if (push) q2.push_back(mk(a, cyc + 1));
        tick();
        rv2 = 1'b0;
        return;
      end
      tick();
    end
    rv2 = 1'b0;
    cmp("issue2_timeout", rdy2, 1);
  endtask

  task automatic issue0(input logic [31:0] a);
    rv0 = 1'b1;
    ra0 = a;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rdy0) begin
        q0.push_back(mk(a, cyc + 1));
        tick();
        rv0 = 1'b0;
        return;
      end
      tick();
    end
    rv0 = 1'b0;
    cmp("issue0_timeout", rdy0, 1);
  endtask

  task automatic wait_v2();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (v2) return;
      tick();
    end
    cmp("wait_valid_timeout", v2, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q2.size() == 0 && !v0 && !v2) begin
        tick();
        return;
      end
      tick();
    end
    cmp("drain_timeout", {31'd0, (q0.size() != 0) | (q2.size() != 0) | v0 | v2}, 0);
  endtask

  // monitor for the two-wait-state instance
  always @(negedge clk) begin
    if (rst) hold2 = 0;
    else if (v2) begin
      cmp("req_ready_in_resp2", rdy2, 0);
      cmp("busy_in_resp2", busy2, 0);
      if (!hold2) begin
        if (q2.size() == 0) cmp("unexpected_resp2", v2, 0);
        else begin
          cur2 = q2.pop_front();
          cmp("latency2", cyc + 1, cur2.t + 1 + W2);
        end
        hold2 = 1;
      end
      cmp("instr2", instr2, cur2.instr);
      cmp("addr2", raddr2, cur2.addr);
      cmp("err2", err2, cur2.err);
      if (rr2) acc2++;
      if (rr2 || flush) hold2 = 0;
    end else hold2 = 0;
  end

  // monitor for the zero-wait-state instance
  always @(negedge clk) begin
    if (rst) hold0 = 0;
    else begin
      cmp("ready_alternates0", rdy0, !v0);
      cmp("busy0", busy0, 0);
      if (v0) begin
        if (!hold0) begin
          if (q0.size() == 0) cmp("unexpected_resp0", v0, 0);
          else begin
            cur0 = q0.pop_front();
            cmp("latency0", cyc + 1, cur0.t + 1);
          end
          hold0 = 1;
        end
        cmp("instr0", instr0, cur0.instr);
        cmp("addr0", raddr0, cur0.addr);
        cmp("err0", err0, cur0.err);
        if (rr0 || flush) hold0 = 0;
      end else hold0 = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, j, sel;
    logic [31:0] a;
    rst = 1'b1; flush = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    rv2 = 1'b0; ra2 = '0; rr2 = 1'b1;
    rv0 = 1'b0; ra0 = '0; rr0 = 1'b1;
    tick();

    // preload during reset
    for (int i = 0; i < 64; i++) load(i, $urandom);
    load(1023, 32'hCAFE_F00D);
    @(negedge clk);
    cmp("rst_valid", v2, 0);
    cmp("rst_instr", instr2, 0);
    cmp("rst_addr", raddr2, 0);
    cmp("rst_err", err2, 0);
    cmp("rst_busy", busy2, 0);
    cmp("rst_ready", rdy2, 0);
    cmp("rst_ready0", rdy0, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    cmp("ready_after_rst", rdy2, 1);
    tick();

    // basic fetch with two wait states
    load(3, 32'h2008_0005);
    issue(32'h0000_000C, 1);
    @(negedge clk); cmp("busy_cycle1", busy2, 1);
    tick(); @(negedge clk); cmp("busy_cycle2", busy2, 1);
    tick(); @(negedge clk); cmp("busy_cycle3", busy2, 0);
    cmp("basic_valid", v2, 1);
    cmp("basic_instr", instr2, 32'h2008_0005);
    tick();
    drain();

    // zero wait states, back to back
    issue0(32'h0); issue0(32'h4); issue0(32'h8); issue0(32'hC);
    drain();

    // load and handshake on the same edge: response sees the old word
    load_en = 1'b1; load_addr = 10'd5; load_data = 32'h5A5A_0005;
    rv0 = 1'b1; ra0 = 32'h14;
    @(negedge clk);
    cmp("same_edge_ready", rdy0, 1);
    if (rdy0) q0.push_back(mk(32'h14, cyc + 1));
    tick();
    mem_m[5] = 32'h5A5A_0005;
    load_en = 1'b0; rv0 = 1'b0;
    drain();
    issue0(32'h14);
    drain();

    // error and boundary addresses
    issue(32'h6, 1);
    issue(32'h1000, 1);
    issue(32'hFFC, 1);
    issue0(32'h3);
    drain();

    // backpressure
    rr2 = 1'b0;
    issue(32'h28, 1);
    wait_v2();
    n = acc2;
    repeat (4) begin
      tick(); @(negedge clk);
      cmp("bp_ready", rdy2, 0);
      cmp("bp_valid", v2, 1);
    end
    tick(); rr2 = 1'b1;
    @(negedge clk);
    tick(); @(negedge clk);
    cmp("bp_single_transfer", acc2, n + 1);
    cmp("bp_valid_drop", v2, 0);
    tick();

    // flush in the second wait cycle, then redirected fetch in the IDLE cycle
    issue(32'h10, 0);
    tick(); flush = 1'b1;
    tick(); flush = 1'b0;
    rv2 = 1'b1; ra2 = 32'h40;
    @(negedge clk);
    cmp("flush_no_valid", v2, 0);
    cmp("flush_idle_busy", busy2, 0);
    cmp("flush_idle_ready", rdy2, 1);
    if (rdy2) q2.push_back(mk(32'h40, cyc + 1));
    tick(); rv2 = 1'b0;
    drain();

    // flush while a response is frozen
    rr2 = 1'b0;
    issue(32'h24, 1);
    wait_v2();
    tick(); flush = 1'b1;
    @(negedge clk);
    tick(); flush = 1'b0;
    @(negedge clk);
    cmp("flush_resp_drop", v2, 0);
    rr2 = 1'b1;
    tick();

    // reset pulse while in WAIT
    issue(32'h20, 0);
    rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    cmp("midrst_valid", v2, 0);
    cmp("midrst_busy", busy2, 0);
    cmp("midrst_ready", rdy2, 1);
    cmp("midrst_addr", raddr2, 0);
    cmp("midrst_instr", instr2, 0);
    tick();
    issue(32'h20, 1);
    issue(32'h0C, 1);
    drain();

    // randomized traffic with backpressure, loads and flushes
    rnd_bp = 1;
    for (int k = 0; k < 80; k++) begin
      for (int i = 0; i < 20 && busy2; i++) tick();
      if ($urandom_range(0, 3) == 0) load($urandom_range(0, 63), $urandom);
      sel = $urandom_range(0, 9);
      if (sel < 6)      a = $urandom_range(0, 63) * 4;
      else if (sel < 8) a = ($urandom_range(0, 63) * 4) | $urandom_range(1, 3);
      else              a = $urandom_range(32'h1000, 32'hFFFF_FFFF);
      if ($urandom_range(0, 4) == 0) begin
        j = $urandom_range(1, W2);
        issue(a, 0);
        repeat (j - 1) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end else issue(a, 1);
    end
    rnd_bp = 0;
    rr2 = 1'b1;
    drain();

    cmp("leftover_q2", q2.size(), 0);
    cmp("leftover_q0", q0.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
